chip8_call_ret_ctrl: RTL and testbench
======================================

// Module: chip8_call_ret_ctrl
// PURPOSE
//  CPU-side initiator for the Chip8 hardware return stack. It turns decoded CALL (2NNN) and
//  RET (00EE) requests into STACK_OP push/pop/hold sequences with exact cycle counts.
//  It supplies the return address and captures the popped address, then hands the CPU a
//  one-cycle PC load. Sits between the instruction decoder/PC logic and the stack block.
// PARAMETERS
//  PUSH_CYCLES  2   consecutive cycles stk_op=STACK_PUSH per call (stack write + pointer increment)
//  POP_CYCLES   2   consecutive cycles stk_op=STACK_POP per return
//  POP_SETTLE   1   STACK_HOLD cycles after the pop before stk_outdata is sampled (also clears stack hold)
//  DEPTH        16  stack entries; used only by the guard feature
// PORTS
//  cpu_clk        in   1   single clock, all logic on posedge
//  reset_n        in   1   synchronous, active-low reset
//  call_req       in   1   level; CALL pending, sampled only in IDLE
//  ret_req        in   1   level; RET pending, sampled only in IDLE
//  call_target    in   12  NNN of 2NNN
//  pc_in          in   16  PC of the current instruction
//  busy           out  1   1 in every state except IDLE
//  done           out  1   1-cycle pulse: operation finished (success or error)
//  pc_load        out  1   1-cycle pulse with done on success: CPU loads pc_out
//  pc_out         out  16  new PC; held until the next done
//  err            out  1   1-cycle pulse with done on over/underflow (guard build only)
//  stk_op         out  STACK_OP  to stack: STACK_PUSH / STACK_POP / STACK_HOLD
//  stk_writedata  out  16  return address to push
//  stk_outdata    in   16  popped data from stack
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state=IDLE, stk_op=STACK_HOLD, stk_writedata=0, pc_out=0,
//    pc_load=0, done=0, busy=0, err=0, counters=0. A reset mid-sequence aborts it at once.
//    The stack must be reset in the same cycle (top level ties both resets).
//  - All outputs are registered and come straight from state/regs; no comb path from req.
//  - FSM: IDLE -> PUSH -> RESP; IDLE -> POP -> SETTLE -> RESP; RESP -> IDLE.
//  - IDLE: stk_op=HOLD. If call_req is sampled, latch ret=pc_in+16'd2 (mod 2^16) and the target.
//    Go to PUSH with cnt=0. Else if ret_req, go to POP. call_req wins when both are high.
//  - PUSH: stk_op=PUSH and stk_writedata=ret, both stable for PUSH_CYCLES cycles.
//    Then go to RESP with pc_out={4'h0,call_target}.
//  - POP: stk_op=POP for POP_CYCLES cycles, then SETTLE.
//  - SETTLE: stk_op=HOLD for POP_SETTLE cycles. On the last cycle, register pc_out<=stk_outdata.
//    Then go to RESP.
//  - RESP: done=1, pc_load=1 (err=0), stk_op=HOLD for one cycle, then IDLE.
//  - Latency from the accepting edge: call done at cycle PUSH_CYCLES+1 (3).
//    Ret done at cycle POP_CYCLES+POP_SETTLE+1 (4).
//  - Requests are ignored while busy. The CPU drops req in the done cycle; a req still high
//    in IDLE afterwards starts a new operation.
//  - Counters are sized $clog2(max(PUSH_CYCLES,POP_CYCLES,POP_SETTLE)+1). No wrap is reachable.
// CONFIGURATION
//  CHIP8_STACK_GUARD_EN defined:
//   - Shadow depth counter 0..DEPTH: +1 on leaving PUSH, -1 on leaving POP, 0 on reset.
//   - call with depth==DEPTH, or ret with depth==0: no stack op issued; go directly to RESP.
//     RESP then pulses done=1, err=1, pc_load=0; pc_out and depth are unchanged.
//  Not defined:
//   - No depth counter; err is tied 0. Every request is issued and stack pointer wrap is
//     left to the stack block.
// STRUCTURE
//  - Shared include enums.svh: existing STACK_OP.
//  - Also in enums.svh: new CALLRET_STATE typedef {CR_IDLE,CR_PUSH,CR_POP,CR_SETTLE,CR_RESP}
//    and constant CHIP8_STACK_DEPTH=16.
//  - One sub-module: chip8_depth_tracker (up/down counter plus full/empty flags).
//    It is instantiated only under CHIP8_STACK_GUARD_EN; everything else stays inline.
// TESTING (bench has a behavioural stack model honouring STACK_OP timing)
//  1 call_req, pc_in=16'h0200, call_target=12'h345 -> stk_op=PUSH for 2 cycles with
//    stk_writedata=16'h0202; cycle 3: done=1, pc_load=1, pc_out=16'h0345; busy=0 at cycle 4.
//  2 ret_req following test 1 -> POP for 2 cycles, HOLD for 1 cycle; cycle 4: done=1, pc_load=1,
//    pc_out=16'h0202.
//  3 call_req and ret_req high in the same cycle -> PUSH sequence; ret ignored until back in IDLE.
//  4 pc_in=16'hFFFE call -> stk_writedata=16'h0000.
//    reset_n=0 during the 2nd PUSH cycle -> next edge stk_op=HOLD, busy=0, pc_out=0, no done.
//  5 GUARD_EN: 16 calls then a 17th -> 17th gives no PUSH cycles; done=1, err=1, pc_load=0.
//    After reset, ret_req -> err=1, no POP issued.
//  6 no GUARD_EN: repeat test 5 -> 17th call issues 2 PUSH cycles; err stays 0.

Source files
------------

// File: rtl/chip8_call_ret_ctrl_pkg.sv
// Shared types and constants for the Chip8 CALL/RET controller and its stack interface.
// Holds the stack operation encoding, the controller state encoding and the default depth.
package chip8_call_ret_ctrl_pkg;

    // Operation presented to the hardware return stack each cycle.
    typedef enum logic [1:0] {
        STACK_HOLD = 2'd0,
        STACK_PUSH = 2'd1,
        STACK_POP  = 2'd2
    } STACK_OP;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        CR_IDLE   = 3'd0,
        CR_PUSH   = 3'd1,
        CR_POP    = 3'd2,
        CR_SETTLE = 3'd3,
        CR_RESP   = 3'd4
    } CALLRET_STATE;

    localparam int CHIP8_STACK_DEPTH = 16;

    // Largest of three timing parameters; sizes the shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/chip8_call_ret_ctrl_if.sv
// Bundle of the CPU-side request/response signals and the stack-side signals of the
// CALL/RET controller. slave = the controller, master = decoder/PC logic plus stack.
interface chip8_call_ret_ctrl_if;
    import chip8_call_ret_ctrl_pkg::*;

    logic        call_req;
    logic        ret_req;
    logic [11:0] call_target;
    logic [15:0] pc_in;
    logic        busy;
    logic        done;
    logic        pc_load;
    logic [15:0] pc_out;
    logic        err;
    STACK_OP     stk_op;
    logic [15:0] stk_writedata;
    logic [15:0] stk_outdata;

    modport slave (
        input  call_req, ret_req, call_target, pc_in, stk_outdata,
        output busy, done, pc_load, pc_out, err, stk_op, stk_writedata
    );

    modport master (
        output call_req, ret_req, call_target, pc_in, stk_outdata,
        input  busy, done, pc_load, pc_out, err, stk_op, stk_writedata
    );

endinterface

// File: rtl/chip8_call_ret_ctrl_depth_tracker.sv
// Shadow depth counter for the return stack: counts 0..DEPTH and flags full/empty.
// Only used by the overflow/underflow guard (CHIP8_STACK_GUARD_EN builds).
module chip8_depth_tracker #(
    parameter int DEPTH = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_empty
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    logic [DEPTH_W-1:0] r_depth;

    // Up/down count, saturating at both ends so a stray pulse can never wrap it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_depth <= '0;
        end else if (i_inc && !i_dec && (r_depth != DEPTH_MAX)) begin
            r_depth <= r_depth + DEPTH_W'(1);
        end else if (i_dec && !i_inc && (r_depth != '0)) begin
            r_depth <= r_depth - DEPTH_W'(1);
        end
    end

    assign o_full  = (r_depth == DEPTH_MAX);
    assign o_empty = (r_depth == '0);

endmodule

// File: rtl/chip8_call_ret_ctrl.sv
// Chip8 CALL/RET controller: turns decoded CALL (2NNN) and RET (00EE) requests into
// timed push/pop/hold sequences for the return stack and hands the CPU a one-cycle PC load.
// Optional build macro CHIP8_STACK_GUARD_EN adds a shadow depth counter that turns stack
// overflow/underflow into an err response instead of a stack operation.
module chip8_call_ret_ctrl
    import chip8_call_ret_ctrl_pkg::*;
#(
    parameter int PUSH_CYCLES = 2,
    parameter int POP_CYCLES  = 2,
    parameter int POP_SETTLE  = 1
`ifdef CHIP8_STACK_GUARD_EN
    ,
    parameter int DEPTH       = CHIP8_STACK_DEPTH
`endif
) (
    input  logic                    cpu_clk,
    input  logic                    reset_n,
    chip8_call_ret_ctrl_if.slave    bus
);

    localparam int CNT_W = $clog2(max3(PUSH_CYCLES, POP_CYCLES, POP_SETTLE) + 1);
    localparam logic [CNT_W-1:0] PUSH_LAST   = CNT_W'(PUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] POP_LAST    = CNT_W'(POP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(POP_SETTLE - 1);

    CALLRET_STATE      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [11:0]       r_target;
    STACK_OP           r_stk_op;
    logic [15:0]       r_stk_writedata;
    logic [15:0]       r_pc_out;
    logic              r_pc_load;
    logic              r_done;
    logic              r_busy;
    logic              r_err;

    logic              w_full;
    logic              w_empty;

`ifdef CHIP8_STACK_GUARD_EN
    logic              w_inc;
    logic              w_dec;

    // Depth moves when a push or pop sequence completes.
    assign w_inc = (r_state == CR_PUSH) && (r_cnt == PUSH_LAST);
    assign w_dec = (r_state == CR_POP)  && (r_cnt == POP_LAST);

    chip8_depth_tracker #(
        .DEPTH   (DEPTH)
    ) u_depth_tracker (
        .i_clk   (cpu_clk),
        .i_rst_n (reset_n),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
`else
    // No guard: every request goes to the stack, which handles pointer wrap itself.
    assign w_full  = 1'b0;
    assign w_empty = 1'b0;
`endif

    // Sequencer: state, cycle counter and every registered output in one block.
    always_ff @(posedge cpu_clk) begin
        if (!reset_n) begin
            r_state         <= CR_IDLE;
            r_cnt           <= '0;
            r_target        <= '0;
            r_stk_op        <= STACK_HOLD;
            r_stk_writedata <= '0;
            r_pc_out        <= '0;
            r_pc_load       <= 1'b0;
            r_done          <= 1'b0;
            r_busy          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            // NOTE: one-cycle pulses default low here so each state only raises them.
            r_done    <= 1'b0;
            r_pc_load <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                CR_IDLE: begin
                    r_stk_op <= STACK_HOLD;
                    r_cnt    <= '0;
                    if (bus.call_req) begin
                        r_stk_writedata <= bus.pc_in + 16'd2;
                        r_target        <= bus.call_target;
                        r_busy          <= 1'b1;
                        if (w_full) begin
                            r_state <= CR_RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state  <= CR_PUSH;
                            r_stk_op <= STACK_PUSH;
                        end
                    end else if (bus.ret_req) begin
                        r_busy <= 1'b1;
                        if (w_empty) begin
                            r_state <= CR_RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state  <= CR_POP;
                            r_stk_op <= STACK_POP;
                        end
                    end
                end
                CR_PUSH: begin
                    if (r_cnt == PUSH_LAST) begin
                        r_state   <= CR_RESP;
                        r_cnt     <= '0;
                        r_stk_op  <= STACK_HOLD;
                        r_pc_out  <= {4'h0, r_target};
                        r_done    <= 1'b1;
                        r_pc_load <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                CR_POP: begin
                    if (r_cnt == POP_LAST) begin
                        r_state  <= CR_SETTLE;
                        r_cnt    <= '0;
                        r_stk_op <= STACK_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                CR_SETTLE: begin
                    // Stack output is only trusted on the last settle cycle.
                    if (r_cnt == SETTLE_LAST) begin
                        r_state   <= CR_RESP;
                        r_cnt     <= '0;
                        r_pc_out  <= bus.stk_outdata;
                        r_done    <= 1'b1;
                        r_pc_load <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                CR_RESP: begin
                    r_state  <= CR_IDLE;
                    r_stk_op <= STACK_HOLD;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state  <= CR_IDLE;
                    r_cnt    <= '0;
                    r_stk_op <= STACK_HOLD;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.pc_load       = r_pc_load;
    assign bus.pc_out        = r_pc_out;
    assign bus.err           = r_err;
    assign bus.stk_op        = r_stk_op;
    assign bus.stk_writedata = r_stk_writedata;

endmodule

// File: tb/tb_chip8_call_ret_ctrl.sv
// Self-checking bench for chip8_call_ret_ctrl with a behavioural return-stack model.
// Expected responses are queued when a request is driven and compared at done.
// Define CHIP8_STACK_GUARD_EN for both RTL and bench to exercise the guard build.
module tb_chip8_call_ret_ctrl;
    import chip8_call_ret_ctrl_pkg::*;

    typedef struct packed {
        logic        pc_load;
        logic        err;
        logic [15:0] pc_out;
    } exp_t;

    logic cpu_clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    always #5 cpu_clk = ~cpu_clk;

    chip8_call_ret_ctrl_if bus();

    chip8_call_ret_ctrl dut (
        .cpu_clk (cpu_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Stack model: push writes on its first cycle and bumps the pointer on the second;
    // pop drops the pointer on its first cycle and presents data on the second.
    logic [15:0] mem [16];
    logic [3:0]  sp;
    int          run;

    always @(posedge cpu_clk) begin
        if (!reset_n) begin
            sp              <= 4'd0;
            run             <= 0;
            bus.stk_outdata <= 16'h0000;
        end else begin
            case (bus.stk_op)
                STACK_PUSH: begin
                    if (run == 0) mem[sp] <= bus.stk_writedata;
                    else if (run == 1) sp <= sp + 4'd1;
                    run <= run + 1;
                end
                STACK_POP: begin
                    if (run == 0) sp <= sp - 4'd1;
                    else if (run == 1) bus.stk_outdata <= mem[sp];
                    run <= run + 1;
                end
                default: run <= 0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic pl, input logic er, input logic [15:0] pc);
        exp_t e;
        e.pc_load = pl;
        e.err     = er;
        e.pc_out  = pc;
        return e;
    endfunction

    // Starts at a negedge in IDLE, returns at the negedge of the IDLE cycle after done.
    task automatic do_op(input logic c, input logic r, input logic [11:0] tgt,
                         input logic [15:0] pc, input int n_push, input int n_pop,
                         input int n_settle, input logic [15:0] exp_wdata,
                         input exp_t e, input logic keep_ret);
        exp_t got;
        bus.call_req    = c;
        bus.ret_req     = r;
        bus.call_target = tgt;
        bus.pc_in       = pc;
        exp_q.push_back(e);
        @(posedge cpu_clk);
        for (int i = 0; i < n_push; i++) begin
            @(negedge cpu_clk);
            check("push_op", 32'(bus.stk_op), 32'(STACK_PUSH));
            check("push_wdata", 32'(bus.stk_writedata), 32'(exp_wdata));
            check("push_busy", 32'(bus.busy), 32'd1);
            check("push_done", 32'(bus.done), 32'd0);
        end
        for (int i = 0; i < n_pop; i++) begin
            @(negedge cpu_clk);
            check("pop_op", 32'(bus.stk_op), 32'(STACK_POP));
            check("pop_done", 32'(bus.done), 32'd0);
        end
        for (int i = 0; i < n_settle; i++) begin
            @(negedge cpu_clk);
            check("settle_op", 32'(bus.stk_op), 32'(STACK_HOLD));
            check("settle_done", 32'(bus.done), 32'd0);
        end
        @(negedge cpu_clk);
        got = exp_q.pop_front();
        check("done", 32'(bus.done), 32'd1);
        check("pc_load", 32'(bus.pc_load), 32'(got.pc_load));
        check("err", 32'(bus.err), 32'(got.err));
        check("pc_out", 32'(bus.pc_out), 32'(got.pc_out));
        check("resp_op", 32'(bus.stk_op), 32'(STACK_HOLD));
        check("resp_busy", 32'(bus.busy), 32'd1);
        bus.call_req = 1'b0;
        bus.ret_req  = keep_ret;
        @(negedge cpu_clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.call_req    = 1'b0;
        bus.ret_req     = 1'b0;
        bus.call_target = 12'h000;
        bus.pc_in       = 16'h0000;
        reset_n         = 1'b0;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        check("rst_op", 32'(bus.stk_op), 32'(STACK_HOLD));
        check("rst_wdata", 32'(bus.stk_writedata), 32'h0);
        check("rst_pc_out", 32'(bus.pc_out), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pc_load", 32'(bus.pc_load), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        reset_n = 1'b1;
        @(negedge cpu_clk);

        // Test 1: CALL 345 from 0200.
        do_op(1'b1, 1'b0, 12'h345, 16'h0200, 2, 0, 0, 16'h0202, mk(1'b1, 1'b0, 16'h0345), 1'b0);
        // Test 2: RET returns to 0202.
        do_op(1'b0, 1'b1, 12'h000, 16'h0000, 0, 2, 1, 16'h0000, mk(1'b1, 1'b0, 16'h0202), 1'b0);
        // Test 3: both requests high; CALL wins, RET held and served right after.
        do_op(1'b1, 1'b1, 12'hABC, 16'h0300, 2, 0, 0, 16'h0302, mk(1'b1, 1'b0, 16'h0ABC), 1'b1);
        do_op(1'b0, 1'b1, 12'h000, 16'h0000, 0, 2, 1, 16'h0000, mk(1'b1, 1'b0, 16'h0302), 1'b0);

        // Test 4: return address wraps, then reset aborts the push mid-sequence.
        bus.call_req    = 1'b1;
        bus.call_target = 12'h123;
        bus.pc_in       = 16'hFFFE;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        bus.call_req = 1'b0;
        check("wrap_op1", 32'(bus.stk_op), 32'(STACK_PUSH));
        check("wrap_wdata", 32'(bus.stk_writedata), 32'h0000);
        @(negedge cpu_clk);
        check("wrap_op2", 32'(bus.stk_op), 32'(STACK_PUSH));
        reset_n = 1'b0;
        @(negedge cpu_clk);
        reset_n = 1'b1;
        check("abort_op", 32'(bus.stk_op), 32'(STACK_HOLD));
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_pc_out", 32'(bus.pc_out), 32'h0);
        check("abort_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge cpu_clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
            check("abort_idle_op", 32'(bus.stk_op), 32'(STACK_HOLD));
        end

        // Tests 5/6: fill the stack with 16 calls, then a 17th.
        for (int i = 0; i < 16; i++) begin
            logic [11:0] t;
            logic [15:0] p;
            t = 12'h500 + 12'(i);
            p = 16'h0400 + 16'(2 * i);
            do_op(1'b1, 1'b0, t, p, 2, 0, 0, p + 16'd2, mk(1'b1, 1'b0, {4'h0, t}), 1'b0);
        end
`ifdef CHIP8_STACK_GUARD_EN
        do_op(1'b1, 1'b0, 12'h777, 16'h0600, 0, 0, 0, 16'h0000, mk(1'b0, 1'b1, 16'h050F), 1'b0);
        reset_n = 1'b0;
        @(negedge cpu_clk);
        reset_n = 1'b1;
        @(negedge cpu_clk);
        do_op(1'b0, 1'b1, 12'h000, 16'h0000, 0, 0, 0, 16'h0000, mk(1'b0, 1'b1, 16'h0000), 1'b0);
`else
        do_op(1'b1, 1'b0, 12'h777, 16'h0600, 2, 0, 0, 16'h0602, mk(1'b1, 1'b0, 16'h0777), 1'b0);
        // Pointer wrapped in the stack, so the 17th entry overwrote the first slot.
        do_op(1'b0, 1'b1, 12'h000, 16'h0000, 0, 2, 1, 16'h0000, mk(1'b1, 1'b0, 16'h0602), 1'b0);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
